// File: rtl/spad_head_if.sv
// Request/response types and the bundled FE/BE/downstream port group of the scratchpad head.
// Every signal is an array indexed by scratchpad number.
package spad_head_pkg;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  mask;
  } xbar_t;

  typedef struct packed {
    xbar_t xbar;
  } rd_req_t;

  typedef struct packed {
    xbar_t       xbar;
    logic [31:0] wdata;
  } wr_req_t;

  typedef struct packed {
    logic  valid;
    src_t  src;
    xbar_t xbar;
  } sel_rd_req_t;

  typedef struct packed {
    logic        valid;
    src_t        src;
    xbar_t       xbar;
    logic [31:0] wdata;
  } sel_wr_req_t;

endpackage

interface spad_head_if #(
  parameter int unsigned NumScpads = 1
);
  import spad_head_pkg::*;

  logic [NumScpads-1:0] fe_rd_req_valid;
  logic [NumScpads-1:0] fe_wr_req_valid;
  logic [NumScpads-1:0] be_rd_req_valid;
  logic [NumScpads-1:0] be_wr_req_valid;
  rd_req_t              fe_rd_req [NumScpads];
  wr_req_t              fe_wr_req [NumScpads];
  rd_req_t              be_rd_req [NumScpads];
  wr_req_t              be_wr_req [NumScpads];
  logic [NumScpads-1:0] r_stall;
  logic [NumScpads-1:0] w_stall;
  logic [NumScpads-1:0] fe_stall;
  logic [NumScpads-1:0] be_stall;
  sel_rd_req_t          head_stomach_rd_req [NumScpads];
  sel_wr_req_t          head_stomach_wr_req [NumScpads];

  modport master (
    output fe_rd_req_valid, fe_wr_req_valid, be_rd_req_valid, be_wr_req_valid,
    output fe_rd_req, fe_wr_req, be_rd_req, be_wr_req,
    output r_stall, w_stall,
    input  fe_stall, be_stall, head_stomach_rd_req, head_stomach_wr_req
  );

  modport slave (
    input  fe_rd_req_valid, fe_wr_req_valid, be_rd_req_valid, be_wr_req_valid,
    input  fe_rd_req, fe_wr_req, be_rd_req, be_wr_req,
    input  r_stall, w_stall,
    output fe_stall, be_stall, head_stomach_rd_req, head_stomach_wr_req
  );

endinterface

// File: rtl/spad_head.sv
// Scratchpad request head: per-channel FE/BE arbitration with BE priority and an FE starvation
// guard, registering the winner into the body stage.
module spad_head #(
  parameter int unsigned IDX          = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic        clk,
  input logic        rst,
  spad_head_if.slave scpad
);
  import spad_head_pkg::*;

  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  sel_rd_req_t rd_q, rd_d;
  sel_wr_req_t wr_q, wr_d;
  logic [7:0]  starve_rd_q, starve_rd_d;
  logic [7:0]  starve_wr_q, starve_wr_d;

  logic fe_rd_v, be_rd_v, fe_wr_v, be_wr_v;
  logic can_load_rd, can_load_wr;
  logic grant_fe_rd, grant_be_rd, grant_fe_wr, grant_be_wr;

  // BE wins a tie unless FE has already waited out StarveMax BE grants.
  always_comb begin
    fe_rd_v     = scpad.fe_rd_req_valid[IDX];
    be_rd_v     = scpad.be_rd_req_valid[IDX];
    fe_wr_v     = scpad.fe_wr_req_valid[IDX];
    be_wr_v     = scpad.be_wr_req_valid[IDX];
    can_load_rd = !rd_q.valid || !scpad.r_stall[IDX];
    can_load_wr = !wr_q.valid || !scpad.w_stall[IDX];
    grant_be_rd = !rst && can_load_rd && be_rd_v && !(fe_rd_v && starve_rd_q == StarveMax);
    grant_fe_rd = !rst && can_load_rd && fe_rd_v && !(be_rd_v && starve_rd_q != StarveMax);
    grant_be_wr = !rst && can_load_wr && be_wr_v && !(fe_wr_v && starve_wr_q == StarveMax);
    grant_fe_wr = !rst && can_load_wr && fe_wr_v && !(be_wr_v && starve_wr_q != StarveMax);
  end

  always_comb begin
    rd_d        = rd_q;
    starve_rd_d = starve_rd_q;
    if (can_load_rd) begin
      rd_d.valid = grant_fe_rd || grant_be_rd;
      if (grant_be_rd) begin
        rd_d.src  = SRC_BE;
        rd_d.xbar = scpad.be_rd_req[IDX].xbar;
      end else if (grant_fe_rd) begin
        rd_d.src  = SRC_FE;
        rd_d.xbar = scpad.fe_rd_req[IDX].xbar;
      end
    end
    if (!fe_rd_v || grant_fe_rd) begin
      starve_rd_d = '0;
    end else if (grant_be_rd && starve_rd_q != StarveMax) begin
      starve_rd_d = starve_rd_q + 8'd1;
    end
  end

  always_comb begin
    wr_d        = wr_q;
    starve_wr_d = starve_wr_q;
    if (can_load_wr) begin
      wr_d.valid = grant_fe_wr || grant_be_wr;
      if (grant_be_wr) begin
        wr_d.src   = SRC_BE;
        wr_d.xbar  = scpad.be_wr_req[IDX].xbar;
        wr_d.wdata = scpad.be_wr_req[IDX].wdata;
      end else if (grant_fe_wr) begin
        wr_d.src   = SRC_FE;
        wr_d.xbar  = scpad.fe_wr_req[IDX].xbar;
        wr_d.wdata = scpad.fe_wr_req[IDX].wdata;
      end
    end
    if (!fe_wr_v || grant_fe_wr) begin
      starve_wr_d = '0;
    end else if (grant_be_wr && starve_wr_q != StarveMax) begin
      starve_wr_d = starve_wr_q + 8'd1;
    end
  end

  // Reset forces both stalls so nothing is consumed while the head is being cleared.
  always_comb begin
    scpad.fe_stall[IDX] = rst | (fe_rd_v & ~grant_fe_rd) | (fe_wr_v & ~grant_fe_wr);
    scpad.be_stall[IDX] = rst | (be_rd_v & ~grant_be_rd) | (be_wr_v & ~grant_be_wr);
    scpad.head_stomach_rd_req[IDX] = rd_q;
    scpad.head_stomach_wr_req[IDX] = wr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= '0;
      wr_q        <= '0;
      starve_rd_q <= '0;
      starve_wr_q <= '0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      starve_rd_q <= starve_rd_d;
      starve_wr_q <= starve_wr_d;
    end
  end

endmodule

// File: tb/tb_spad_head.sv
// Directed bench for spad_head: reset, single reads, write arbitration, starvation guard,
// downstream stall, channel independence and mid-operation reset.
module tb_spad_head;
  import spad_head_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spad_head_if #(.NumScpads(1)) bus ();

  spad_head #(
    .IDX         (0),
    .STARVE_LIMIT(3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .scpad(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fe_rd_req_valid = '0;
    bus.fe_wr_req_valid = '0;
    bus.be_rd_req_valid = '0;
    bus.be_wr_req_valid = '0;
    bus.fe_rd_req[0]    = '0;
    bus.fe_wr_req[0]    = '0;
    bus.be_rd_req[0]    = '0;
    bus.be_wr_req[0]    = '0;
    bus.r_stall         = '0;
    bus.w_stall         = '0;
  endtask

  function automatic rd_req_t mk_rd(input logic [15:0] addr);
    rd_req_t r;
    r.xbar.addr = addr;
    r.xbar.mask = 4'hf;
    return r;
  endfunction

  function automatic wr_req_t mk_wr(input logic [15:0] addr, input logic [31:0] data);
    wr_req_t w;
    w.xbar.addr = addr;
    w.xbar.mask = 4'h3;
    w.wdata     = data;
    return w;
  endfunction

  // A source presenting rd and wr in the same cycle breaks the re-present rule.
  always @(negedge clk) begin
    if (rst === 1'b0 &&
        ((bus.fe_rd_req_valid[0] && bus.fe_wr_req_valid[0]) ||
         (bus.be_rd_req_valid[0] && bus.be_wr_req_valid[0]))) begin
      errors++;
      $error("FAIL protocol: rd and wr asserted together by one source");
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_rd_valid", 64'(bus.head_stomach_rd_req[0].valid), 64'(0));
    chk("rst_wr_valid", 64'(bus.head_stomach_wr_req[0].valid), 64'(0));
    chk("rst_fe_stall", 64'(bus.fe_stall[0]), 64'(1));
    chk("rst_be_stall", 64'(bus.be_stall[0]), 64'(1));

    // Single FE read.
    rst = 1'b0;
    bus.fe_rd_req_valid[0] = 1'b1;
    bus.fe_rd_req[0]       = mk_rd(16'h0010);
    #1;
    chk("fe_rd_stall", 64'(bus.fe_stall[0]), 64'(0));
    tick();
    idle();
    chk("fe_rd_valid", 64'(bus.head_stomach_rd_req[0].valid), 64'(1));
    chk("fe_rd_src", 64'(bus.head_stomach_rd_req[0].src), 64'(SRC_FE));
    chk("fe_rd_addr", 64'(bus.head_stomach_rd_req[0].xbar.addr), 64'h10);
    chk("fe_rd_mask", 64'(bus.head_stomach_rd_req[0].xbar.mask), 64'hf);
    tick();
    chk("fe_rd_drain", 64'(bus.head_stomach_rd_req[0].valid), 64'(0));

    // Simultaneous FE/BE write: BE first, FE next.
    bus.fe_wr_req_valid[0] = 1'b1;
    bus.fe_wr_req[0]       = mk_wr(16'h0020, 32'hA1A1_A1A1);
    bus.be_wr_req_valid[0] = 1'b1;
    bus.be_wr_req[0]       = mk_wr(16'h0030, 32'hB2B2_B2B2);
    #1;
    chk("wr2_be_stall", 64'(bus.be_stall[0]), 64'(0));
    chk("wr2_fe_stall", 64'(bus.fe_stall[0]), 64'(1));
    tick();
    bus.be_wr_req_valid[0] = 1'b0;
    chk("wr2_src0", 64'(bus.head_stomach_wr_req[0].src), 64'(SRC_BE));
    chk("wr2_data0", 64'(bus.head_stomach_wr_req[0].wdata), 64'hB2B2_B2B2);
    #1;
    chk("wr2_fe_stall1", 64'(bus.fe_stall[0]), 64'(0));
    tick();
    idle();
    chk("wr2_src1", 64'(bus.head_stomach_wr_req[0].src), 64'(SRC_FE));
    chk("wr2_data1", 64'(bus.head_stomach_wr_req[0].wdata), 64'hA1A1_A1A1);
    chk("wr2_addr1", 64'(bus.head_stomach_wr_req[0].xbar.addr), 64'h20);
    tick();

    // Starvation guard at limit 3: BE,BE,BE,FE repeated.
    bus.fe_rd_req_valid[0] = 1'b1;
    bus.fe_rd_req[0]       = mk_rd(16'h0aaa);
    bus.be_rd_req_valid[0] = 1'b1;
    bus.be_rd_req[0]       = mk_rd(16'h0bbb);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("starve_src%0d", i), 64'(bus.head_stomach_rd_req[0].src),
          (i % 4 == 3) ? 64'(SRC_FE) : 64'(SRC_BE));
    end
    idle();
    tick();

    // Downstream write stall with FE pending.
    bus.be_wr_req_valid[0] = 1'b1;
    bus.be_wr_req[0]       = mk_wr(16'h0040, 32'hC3C3_C3C3);
    tick();
    bus.be_wr_req_valid[0] = 1'b0;
    bus.fe_wr_req_valid[0] = 1'b1;
    bus.fe_wr_req[0]       = mk_wr(16'h0050, 32'hD4D4_D4D4);
    bus.w_stall[0]         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wstall_fe_stall%0d", i), 64'(bus.fe_stall[0]), 64'(1));
      tick();
      chk($sformatf("wstall_hold%0d", i), 64'(bus.head_stomach_wr_req[0].wdata), 64'hC3C3_C3C3);
      chk($sformatf("wstall_src%0d", i), 64'(bus.head_stomach_wr_req[0].src), 64'(SRC_BE));
    end
    bus.w_stall[0] = 1'b0;
    #1;
    chk("wstall_release", 64'(bus.fe_stall[0]), 64'(0));
    tick();
    idle();
    chk("wstall_fe_src", 64'(bus.head_stomach_wr_req[0].src), 64'(SRC_FE));
    chk("wstall_fe_data", 64'(bus.head_stomach_wr_req[0].wdata), 64'hD4D4_D4D4);
    tick();

    // Read stall leaves the write channel free.
    bus.be_rd_req_valid[0] = 1'b1;
    bus.be_rd_req[0]       = mk_rd(16'h0060);
    tick();
    bus.be_rd_req_valid[0] = 1'b0;
    bus.r_stall[0]         = 1'b1;
    bus.be_wr_req_valid[0] = 1'b1;
    bus.be_wr_req[0]       = mk_wr(16'h0070, 32'hE5E5_E5E5);
    #1;
    chk("indep_be_stall", 64'(bus.be_stall[0]), 64'(0));
    tick();
    chk("indep_wr_valid", 64'(bus.head_stomach_wr_req[0].valid), 64'(1));
    chk("indep_wr_data", 64'(bus.head_stomach_wr_req[0].wdata), 64'hE5E5_E5E5);
    chk("indep_rd_valid", 64'(bus.head_stomach_rd_req[0].valid), 64'(1));
    chk("indep_rd_addr", 64'(bus.head_stomach_rd_req[0].xbar.addr), 64'h60);
    idle();
    tick();

    // Reset mid-operation with both outputs valid and starve_rd at 2.
    bus.be_wr_req_valid[0] = 1'b1;
    bus.be_wr_req[0]       = mk_wr(16'h0090, 32'h6666_6666);
    tick();
    bus.be_wr_req_valid[0] = 1'b0;
    bus.w_stall[0]         = 1'b1;
    bus.fe_rd_req_valid[0] = 1'b1;
    bus.fe_rd_req[0]       = mk_rd(16'h00f1);
    bus.be_rd_req_valid[0] = 1'b1;
    bus.be_rd_req[0]       = mk_rd(16'h00f2);
    tick();
    tick();
    chk("pre_rst_rd_valid", 64'(bus.head_stomach_rd_req[0].valid), 64'(1));
    chk("pre_rst_wr_valid", 64'(bus.head_stomach_wr_req[0].valid), 64'(1));
    chk("pre_rst_starve", 64'(dut.starve_rd_q), 64'(2));
    rst = 1'b1;
    #1;
    chk("mid_rst_fe_stall", 64'(bus.fe_stall[0]), 64'(1));
    chk("mid_rst_be_stall", 64'(bus.be_stall[0]), 64'(1));
    tick();
    chk("post_rst_rd_valid", 64'(bus.head_stomach_rd_req[0].valid), 64'(0));
    chk("post_rst_wr_valid", 64'(bus.head_stomach_wr_req[0].valid), 64'(0));
    chk("post_rst_starve_rd", 64'(dut.starve_rd_q), 64'(0));
    chk("post_rst_starve_wr", 64'(dut.starve_wr_q), 64'(0));
    chk("post_rst_fe_stall", 64'(bus.fe_stall[0]), 64'(1));
    chk("post_rst_be_stall", 64'(bus.be_stall[0]), 64'(1));
    rst = 1'b0;
    idle();
    bus.fe_rd_req_valid[0] = 1'b1;
    bus.fe_rd_req[0]       = mk_rd(16'h0080);
    #1;
    chk("after_rst_stall", 64'(bus.fe_stall[0]), 64'(0));
    tick();
    idle();
    chk("after_rst_valid", 64'(bus.head_stomach_rd_req[0].valid), 64'(1));
    chk("after_rst_src", 64'(bus.head_stomach_rd_req[0].src), 64'(SRC_FE));
    chk("after_rst_addr", 64'(bus.head_stomach_rd_req[0].xbar.addr), 64'h80);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spad_head.md
# spad_head

Per-scratchpad request head. It takes read and write requests from the frontend (FE, vector core) and the backend (BE, DRAM/scheduler side), arbitrates each channel independently with BE priority and a bounded FE starvation guard, and registers the winner into the body stage (`head_stomach_rd_req` / `head_stomach_wr_req`). It back-pressures FE and BE whenever their request is not taken. It sits between the FE/BE blocks and the write crossbar / SRAM controller of scratchpad `IDX`.

## Interface
- `IDX`, 0: scratchpad index; selects element `[IDX]` of every `scpad_if` array.
- `STARVE_LIMIT`, 8: consecutive BE grants a waiting FE tolerates before it is forced through. Legal range is 1–255.
- `clk`  in  1: clock.
- `rst`  in  1: reset. Synchronous and active-high.
- `w_stall`, `r_stall`  in  1 each: downstream backpressure for the write and read paths.
- `fe_rd_req_valid`/`fe_rd_req`, `fe_wr_req_valid`/`fe_wr_req`  in  1 / `rd_req_t`, `wr_req_t`: FE requests.
- `be_rd_req_valid`/`be_rd_req`, `be_wr_req_valid`/`be_wr_req`  in  1 / `rd_req_t`, `wr_req_t`: BE requests.
- `fe_stall`, `be_stall`  out  1 each: the requester must hold its request unchanged.
- `head_stomach_rd_req`  out  `sel_rd_req_t`: registered read winner `{valid, src, xbar}`.
- `head_stomach_wr_req`  out  `sel_wr_req_t`: registered write winner `{valid, src, xbar, wdata}`.

## Operation
- The read and write channels are identical, independent instances of the logic below. `ch` stands for rd or wr.
- **Output register per channel:** `out_ch` (valid, src, xbar, plus wdata on the write channel).
- `can_load_ch = !out_ch.valid | !ch_stall`.
- **Arbitration**, evaluated when `can_load_ch`:
  - If only one source is valid, that source wins.
  - If both are valid, BE wins unless `starve_ch == STARVE_LIMIT`; in that case FE wins.
- **Load:**
  - On a win, `out_ch` takes `valid=1`, `src` set to `SRC_BE` or `SRC_FE`, and `xbar` (and `wdata`) from the winning request.
  - If `can_load_ch` is true and there is no request, `out_ch.valid` becomes 0.
  - If `can_load_ch` is false, `out_ch` holds all fields.
- **Starvation counter** `starve_ch` (8-bit):
  - Increments on a BE grant while FE on the same channel is valid.
  - Clears on any FE grant, and on any cycle where FE on that channel is not valid.
  - Saturates at `STARVE_LIMIT`.
- **Grant and stall:**
  - `grant_src_ch` is true when `src` is valid on `ch` and wins arbitration this cycle.
  - `fe_stall = (fe_rd_req_valid & !grant_fe_rd) | (fe_wr_req_valid & !grant_fe_wr)`. `be_stall` is the same with BE signals.
  - Stalls are combinational from the current valids, the output register state, and the downstream stalls.
  - A source that is granted on one channel and stalled on the other sees `stall=1`. It re-presents both requests, and the already-granted one is consumed again. Therefore FE and BE must not assert rd and wr in the same cycle. The bench flags a violation of this rule as an error.
- **Reset** (`rst` high at a rising edge):
  - `out_rd.valid = out_wr.valid = 0`, and the `src`/`xbar`/`wdata` fields are 0.
  - `starve_rd = starve_wr = 0`.
  - While `rst` is high, `fe_stall = be_stall = 1` and no grant occurs.
  - A request pending at reset is dropped. The requester re-issues it after `rst` falls.

## Timing
- Latency is one cycle: a request granted in cycle N appears on `head_stomach_*_req` in cycle N+1.
- Throughput is one request per channel per cycle while the downstream stall is low. rd and wr proceed concurrently.
- A downstream stall in cycle N freezes the output register at edge N and blocks all grants on that channel in cycle N.
- On the first cycle the downstream stall is low again, the held entry drains and a new grant loads in the same cycle, with no bubble.
- Both sources stalled: both stall outputs are 1, because both are blocked by `!can_load`.
- Forced FE slot: with both sources continuously valid, the channel issues STARVE_LIMIT BE grants, then 1 FE grant, then repeats.

## Test plan
- **Single FE read:**
  - Stimulus: FE read with `addr=0x10`, idle otherwise.
  - Required response: cycle+1 shows `head_stomach_rd_req.valid=1`, `src=SRC_FE`, `xbar` matching the request; `fe_stall=0` throughout.
- **Simultaneous FE/BE write:**
  - Stimulus: FE and BE write together.
  - Required response: BE granted first with `be_stall=0`, `fe_stall=1`. FE is granted the next cycle, and the outputs show `src` BE then FE with matching `wdata`.
- **Starvation guard:**
  - Stimulus: `STARVE_LIMIT=3`, FE and BE read valid for 12 cycles.
  - Required response: grant sequence BE, BE, BE, FE, repeated 3 times.
- **Downstream stall:**
  - Stimulus: BE write loaded, then `w_stall=1` for 4 cycles while FE write is pending.
  - Required response: output held constant; `fe_stall=1` for all 4 cycles. The FE write loads on the first cycle with `w_stall=0` and appears the next cycle.
- **Channel independence:**
  - Stimulus: `r_stall=1` held while a BE write is issued.
  - Required response: the write passes with 1-cycle latency; the read output is unaffected.
- **Reset mid-operation:**
  - Stimulus: assert `rst` with both output registers valid and `starve=2`.
  - Required response: the next cycle shows both valids 0, counters 0, and both stalls 1 while `rst` is high. The first request after reset is granted normally.
